// File: rtl/instruction_memory.sv
// instruction_memory: 4096 x 32-bit instruction store with a registered, read-first read port
// and a byte-lane write port sharing one address. Boot image enabled by INSTRUCTION_MEMORY_BOOT_PROGRAM_EN.
module instruction_memory (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [11:0] Address,
    input  logic        Ena,
    input  logic [3:0]  Wea,
    input  logic [31:0] InsInput,
    output logic [31:0] Instruction
);

    // Contents are power-up initialised only; reset never touches the array.
`ifdef INSTRUCTION_MEMORY_BOOT_PROGRAM_EN
    logic [31:0] r_mem [0:4095] = '{
        0: 32'hA5A5_0000, 1: 32'hA5A5_0001, 2: 32'hA5A5_0002, 3: 32'hA5A5_0003,
        4: 32'hA5A5_0004, 5: 32'hA5A5_0005, 6: 32'hA5A5_0006, 7: 32'hA5A5_0007,
        default: 32'h0000_0000
    };
`else
    logic [31:0] r_mem [0:4095] = '{default: 32'h0000_0000};
`endif

    logic [31:0] r_instruction;
    logic        w_access;

    assign w_access    = Ena && Rst;
    assign Instruction = r_instruction;

    // Byte-lane write; edges seen while reset is held must not modify the array.
    always_ff @(posedge Clk) begin
        if (w_access) begin
            for (int i = 0; i < 4; i++) begin
                if (Wea[i]) begin
                    r_mem[Address][8*i +: 8] <= InsInput[8*i +: 8];
                end
            end
        end
    end

    // Registered read; sampling r_mem before the write commits gives read-first behaviour.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_instruction <= 32'h0000_0000;
        end else if (Ena) begin
            r_instruction <= r_mem[Address];
        end else begin
            r_instruction <= r_instruction;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_instruction_memory;

    logic        Clk;
    logic        Rst;
    logic [11:0] Address;
    logic        Ena;
    logic [3:0]  Wea;
    logic [31:0] InsInput;
    logic [31:0] Instruction;

    int          n_cmp;
    int          n_err;
    logic [31:0] model_mem [0:4095];
    logic [31:0] exp_out;

    instruction_memory dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Address     (Address),
        .Ena         (Ena),
        .Wea         (Wea),
        .InsInput    (InsInput),
        .Instruction (Instruction)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after a falling edge, model the rising edge, check on the next falling edge.
    task automatic cycle(input string tag, input logic ena, input logic [3:0] wea,
                         input logic [11:0] addr, input logic [31:0] data);
        logic rst_at_edge;
        Ena      = ena;
        Wea      = wea;
        Address  = addr;
        InsInput = data;
        @(posedge Clk);
        rst_at_edge = Rst;
        if (!rst_at_edge) begin
            exp_out = 32'h0000_0000;
        end else if (ena) begin
            exp_out = model_mem[addr];
            for (int b = 0; b < 4; b++) begin
                if (wea[b]) model_mem[addr][8*b +: 8] = data[8*b +: 8];
            end
        end
        @(negedge Clk);
        check(tag, Instruction, exp_out);
    endtask

    task automatic reset_between_edges(input string tag);
        #2;
        Rst = 1'b0;
        #1;
        exp_out = 32'h0000_0000;
        check(tag, Instruction, exp_out);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        Rst      = 1'b1;
        Ena      = 1'b0;
        Wea      = 4'h0;
        Address  = 12'h000;
        InsInput = 32'h0000_0000;
        for (int k = 0; k < 4096; k++) model_mem[k] = 32'h0000_0000;
`ifdef INSTRUCTION_MEMORY_BOOT_PROGRAM_EN
        for (int k = 0; k < 8; k++) model_mem[k] = 32'hA5A5_0000 | 32'(k);
`endif
        // Asynchronous reset with no clock edge yet.
        #2;
        Rst = 1'b0;
        #1;
        check("reset_async", Instruction, 32'h0000_0000);
        @(negedge Clk);
        check("reset_hold", Instruction, 32'h0000_0000);
        Rst = 1'b1;

        for (int k = 0; k < 8; k++) begin
            cycle("boot_read", 1'b1, 4'h0, 12'(k), 32'h0000_0000);
`ifdef INSTRUCTION_MEMORY_BOOT_PROGRAM_EN
            check("boot_word", Instruction, 32'hA5A5_0000 | 32'(k));
`else
            check("boot_word", Instruction, 32'h0000_0000);
`endif
        end

        cycle("wr_full", 1'b1, 4'hF, 12'h100, 32'hDEAD_BEEF);
        cycle("rd_full", 1'b1, 4'h0, 12'h100, 32'h0000_0000);
        check("rd_full_const", Instruction, 32'hDEAD_BEEF);
        cycle("rd_top", 1'b1, 4'h0, 12'hFFF, 32'h0000_0000);
        check("rd_top_const", Instruction, 32'h0000_0000);

        cycle("wr_lane_base", 1'b1, 4'hF, 12'h010, 32'h1122_3344);
        cycle("wr_lane_mask", 1'b1, 4'b0101, 12'h010, 32'hAABB_CCDD);
        cycle("rd_lane", 1'b1, 4'h0, 12'h010, 32'h0000_0000);
        check("rd_lane_const", Instruction, 32'h11BB_33DD);

        cycle("ena_off_hold", 1'b0, 4'hF, 12'h010, 32'hFFFF_FFFF);
        check("ena_off_const", Instruction, 32'h11BB_33DD);
        cycle("ena_off_hold2", 1'b0, 4'hF, 12'h100, 32'hFFFF_FFFF);
        cycle("rd_after_gate", 1'b1, 4'h0, 12'h010, 32'h0000_0000);
        check("rd_after_gate_const", Instruction, 32'h11BB_33DD);

        cycle("rf_seed", 1'b1, 4'hF, 12'h020, 32'h0000_1234);
        cycle("rf_collide", 1'b1, 4'hF, 12'h020, 32'h0000_5678);
        check("rf_old_const", Instruction, 32'h0000_1234);
        cycle("rf_read", 1'b1, 4'h0, 12'h020, 32'h0000_0000);
        check("rf_new_const", Instruction, 32'h0000_5678);

        // Reset mid-operation; the edge inside reset must neither read nor write.
        cycle("mid_rd", 1'b1, 4'h0, 12'h100, 32'h0000_0000);
        reset_between_edges("mid_reset_async");
        cycle("in_reset_edge", 1'b1, 4'hF, 12'h100, 32'h0BAD_0BAD);
        Rst = 1'b1;
        cycle("post_reset_rd", 1'b1, 4'h0, 12'h100, 32'h0000_0000);
        check("post_reset_const", Instruction, 32'hDEAD_BEEF);

        for (int n = 0; n < 1500; n++) begin
            logic        r_ena;
            logic [3:0]  r_wea;
            logic [11:0] r_addr;
            r_ena  = ($urandom % 8) != 0;
            r_wea  = 4'($urandom);
            r_addr = (($urandom % 4) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
            cycle("rand", r_ena, r_wea, r_addr, $urandom);
            if (($urandom % 100) == 0) begin
                reset_between_edges("rand_reset");
                cycle("rand_in_reset", 1'b1, 4'hF, r_addr, $urandom);
                Rst = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
